// File: rtl/tvec_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tvec_seq_pkg
// Description : Shared types and constants for the test-vector sequencer.
//               Holds the sequencer FSM state encoding and the ROM word
//               field offsets (expected response in the low bits, stimulus
//               above it).
// Revision    : 1.0 - initial release
// ============================================================================
package tvec_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } tvec_state_t;

    // Expected response always sits at bit 0 of the ROM word.
    localparam int c_EXP_LSB = 0;

    // Stimulus field starts directly above the expected-response field.
    function automatic int stim_lsb(input int out_w);
        return c_EXP_LSB + out_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tvec_exp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tvec_exp_pipe
// Description : LATENCY-deep shift register carrying {valid, payload} for
//               each applied vector, so the expected response (and
//               optionally its ROM address) reaches the tail exactly when
//               the DUT response for that vector is due.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               in_vld/in_data  - entry stage, shifted in every clock
//               out_vld/out_data - tail stage
// Revision    : 1.0 - initial release
// ============================================================================
module tvec_exp_pipe #(
    parameter int LATENCY = 4,
    parameter int DW      = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [DW-1:0] in_data,
    output logic          out_vld,
    output logic [DW-1:0] out_data
);

    logic [LATENCY-1:0] r_vld;
    logic [DW-1:0]      r_data [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < LATENCY; i++) r_data[i] <= '0;
        end else begin
            r_vld[0]  <= in_vld;
            r_data[0] <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    assign out_vld  = r_vld[LATENCY-1];
    assign out_data = r_data[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/tvec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tvec_sequencer
// Description : Synthesizable test-vector controller. Streams stimulus words
//               from a vector ROM into a DUT at one vector per clock and
//               compares the DUT response against the expected bits LATENCY
//               edges later, counting mismatches (saturating).
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               start, num_vec    - run request and vector count
//               vec_rd, vec_addr, vec_data - vector ROM interface
//               dut_in, dut_out   - DUT stimulus / response
//               busy, done        - run status
//               err_count, err_sat - mismatch counter and saturation flag
// Options     : TVEC_SEQ_FIRST_ERR_EN adds first_err_idx / first_err_vld,
//               the ROM index of the first mismatching vector in a run.
// Revision    : 1.0 - initial release
// ============================================================================
module tvec_sequencer
    import tvec_seq_pkg::*;
#(
    parameter int IN_W    = 3,
    parameter int OUT_W   = 1,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W:0]       num_vec,
    output logic                  vec_rd,
    output logic [ADDR_W-1:0]     vec_addr,
    input  logic [IN_W+OUT_W-1:0] vec_data,
    output logic [IN_W-1:0]       dut_in,
    input  logic [OUT_W-1:0]      dut_out,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      err_count,
    output logic                  err_sat
`ifdef TVEC_SEQ_FIRST_ERR_EN
    ,
    output logic [ADDR_W-1:0]     first_err_idx,
    output logic                  first_err_vld
`endif
);

    localparam int c_WORD_W   = IN_W + OUT_W;
    localparam int c_STIM_LSB = stim_lsb(OUT_W);
    localparam int c_DCNT_W   = $clog2(LATENCY + 1);
    localparam logic [ADDR_W:0]     c_MAX_VEC    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0]    c_CNT_MAX    = '1;
    localparam logic [c_DCNT_W-1:0] c_DRAIN_LAST = c_DCNT_W'(LATENCY);
`ifdef TVEC_SEQ_FIRST_ERR_EN
    localparam int c_PIPE_W = OUT_W + ADDR_W;
`else
    localparam int c_PIPE_W = OUT_W;
`endif

    tvec_state_t         r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_last;      // index of final vector in this run
    logic                r_rd_d;      // vec_data holds a valid word this cycle
    logic [ADDR_W-1:0]   r_addr_d;    // address of that word
    logic [c_DCNT_W-1:0] r_dcnt;

    logic                w_start_ok;
    logic [ADDR_W:0]     w_nv_clamp;
    logic                w_last_applied;
    logic                w_issue_more;
    logic                w_tail_vld;
    logic [c_PIPE_W-1:0] w_pipe_in;
    logic [c_PIPE_W-1:0] w_tail;
    logic [OUT_W-1:0]    w_tail_exp;
    logic                w_mis;

    assign w_start_ok     = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_nv_clamp     = (num_vec > c_MAX_VEC) ? c_MAX_VEC : num_vec;
    assign w_last_applied = r_rd_d && (r_addr_d == r_last);
    assign w_issue_more   = vec_rd && (vec_addr != r_last);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_ok)
                    w_state_nxt = (num_vec == '0) ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: w_state_nxt = ST_RUN;
            ST_RUN:   if (w_last_applied) w_state_nxt = ST_DRAIN;
            // One extra edge beyond LATENCY lets the final compare land in
            // err_count before done is raised.
            ST_DRAIN: if (r_dcnt == c_DRAIN_LAST) w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (r_state == ST_FETCH) || (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done = (r_state == ST_DONE);

    // ------------------------------------------------------------------
    // Sequencing, stimulus register and error counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            vec_rd    <= 1'b0;
            vec_addr  <= '0;
            r_last    <= '0;
            r_rd_d    <= 1'b0;
            r_addr_d  <= '0;
            r_dcnt    <= '0;
            dut_in    <= '0;
            err_count <= '0;
            err_sat   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rd_d   <= vec_rd;
            r_addr_d <= vec_addr;

            if (w_start_ok) begin
                r_last   <= ADDR_W'(w_nv_clamp - 1'b1);
                vec_addr <= '0;
                vec_rd   <= (num_vec != '0);
            end else if (w_issue_more) begin
                vec_addr <= vec_addr + ADDR_W'(1);
            end else begin
                vec_rd   <= 1'b0;
            end

            r_dcnt <= (r_state == ST_DRAIN) ? r_dcnt + c_DCNT_W'(1) : '0;

            if (r_rd_d)
                dut_in <= vec_data[c_WORD_W-1:c_STIM_LSB];

            if (w_start_ok) begin
                err_count <= '0;
                err_sat   <= 1'b0;
            end else if (w_mis && (err_count != c_CNT_MAX)) begin
                err_count <= err_count + CNT_W'(1);
                if (err_count == c_CNT_MAX - CNT_W'(1))
                    err_sat <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Expected-response pipe
    // ------------------------------------------------------------------
`ifdef TVEC_SEQ_FIRST_ERR_EN
    assign w_pipe_in  = {vec_data[c_EXP_LSB +: OUT_W], r_addr_d};
    assign w_tail_exp = w_tail[c_PIPE_W-1:ADDR_W];
`else
    assign w_pipe_in  = vec_data[c_EXP_LSB +: OUT_W];
    assign w_tail_exp = w_tail;
`endif

    tvec_exp_pipe #(
        .LATENCY (LATENCY),
        .DW      (c_PIPE_W)
    ) u_exp_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (r_rd_d),
        .in_data  (w_pipe_in),
        .out_vld  (w_tail_vld),
        .out_data (w_tail)
    );

    assign w_mis = w_tail_vld && (dut_out != w_tail_exp);

`ifdef TVEC_SEQ_FIRST_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else if (w_start_ok) begin
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else if (w_mis && !first_err_vld) begin
            first_err_idx <= w_tail[ADDR_W-1:0];
            first_err_vld <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tvec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tvec_sequencer
// Description : Scoreboard bench for tvec_sequencer. Run stimulus pushes the
//               hand-computed outcome of each run; a monitor pops and checks
//               it when done rises. A second instance with a 2-bit counter
//               exercises saturation. The DUT is a 3-register parity pipeline,
//               so its output is sampled LATENCY=4 edges after dut_in changes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tvec_sequencer;

    localparam int IN_W   = 3;
    localparam int OUT_W  = 1;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // main instance
    logic                  start;
    logic [ADDR_W:0]       num_vec;
    logic                  vec_rd;
    logic [ADDR_W-1:0]     vec_addr;
    logic [IN_W+OUT_W-1:0] vec_data = '0;
    logic [IN_W-1:0]       dut_in;
    logic [OUT_W-1:0]      dut_out;
    logic                  busy, done;
    logic [15:0]           err_count;
    logic                  err_sat;
    // saturation instance
    logic                  start_s;
    logic [ADDR_W:0]       num_vec_s;
    logic                  vec_rd_s;
    logic [ADDR_W-1:0]     vec_addr_s;
    logic [IN_W+OUT_W-1:0] vec_data_s = '0;
    logic [IN_W-1:0]       dut_in_s;
    logic [OUT_W-1:0]      dut_out_s;
    logic                  busy_s, done_s;
    logic [1:0]            err_count_s;
    logic                  err_sat_s;
`ifdef TVEC_SEQ_FIRST_ERR_EN
    logic [ADDR_W-1:0]     first_err_idx, first_err_idx_s;
    logic                  first_err_vld, first_err_vld_s;
`endif

    tvec_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
        .vec_rd(vec_rd), .vec_addr(vec_addr), .vec_data(vec_data),
        .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
        .err_count(err_count), .err_sat(err_sat)
`ifdef TVEC_SEQ_FIRST_ERR_EN
        , .first_err_idx(first_err_idx), .first_err_vld(first_err_vld)
`endif
    );

    tvec_sequencer #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(start_s), .num_vec(num_vec_s),
        .vec_rd(vec_rd_s), .vec_addr(vec_addr_s), .vec_data(vec_data_s),
        .dut_in(dut_in_s), .dut_out(dut_out_s), .busy(busy_s), .done(done_s),
        .err_count(err_count_s), .err_sat(err_sat_s)
`ifdef TVEC_SEQ_FIRST_ERR_EN
        , .first_err_idx(first_err_idx_s), .first_err_vld(first_err_vld_s)
`endif
    );

    // Directed vectors: stimulus and its hand-computed parity.
    logic [2:0] stim_tbl [8] = '{3'd5, 3'd2, 3'd7, 3'd0, 3'd3, 3'd6, 3'd1, 3'd4};
    logic       par_tbl  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] rom [8];

    task automatic load_rom(input logic [7:0] flip);
        for (int k = 0; k < 8; k++) rom[k] = {stim_tbl[k], par_tbl[k] ^ flip[k]};
    endtask

    // synchronous-read ROMs
    always @(posedge clk) if (vec_rd)   vec_data   <= rom[vec_addr[2:0]];
    always @(posedge clk) if (vec_rd_s) vec_data_s <= rom[vec_addr_s[2:0]];

    // parity DUTs, three registers each
    logic m0, m1, m2, s0, s1, s2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {m0, m1, m2} <= 3'b000;
            {s0, s1, s2} <= 3'b000;
        end else begin
            m0 <= ^dut_in;   m1 <= m0; m2 <= m1;
            s0 <= ^dut_in_s; s1 <= s0; s2 <= s1;
        end
    end
    assign dut_out   = m2;
    assign dut_out_s = s2;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int cnt;
        bit sat;
        int cyc;
        bit busy_seen;
        bit fvld;
        int fidx;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    bit   busy_seen = 1'b0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_seen = 1'b1;
        if (done && !prev_done) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check("err_count",  err_count, e.cnt);
                check("err_sat",    err_sat, e.sat);
                check("run_cycles", cyc - start_cyc, e.cyc);
                check("busy_seen",  busy_seen, e.busy_seen);
`ifdef TVEC_SEQ_FIRST_ERR_EN
                check("first_err_vld", first_err_vld, e.fvld);
                if (e.fvld) check("first_err_idx", first_err_idx, e.fidx);
`endif
            end
        end
        prev_done = done;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic run(input int nv, input logic [7:0] flip, input int ecnt,
                       input int ecyc, input bit ebusy, input bit efvld,
                       input int efidx, input bit spurious);
        exp_t e;
        int   waited;
        load_rom(flip);
        e.cnt = ecnt; e.sat = 1'b0; e.cyc = ecyc; e.busy_seen = ebusy;
        e.fvld = efvld; e.fidx = efidx;
        @(posedge clk); #1;
        num_vec = (ADDR_W+1)'(nv);
        start   = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
        busy_seen = 1'b0;
        if (spurious) begin
            repeat (4) @(posedge clk);
            #1; num_vec = 11'd3; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
        end
        waited = 0;
        while (!done && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!done) check("done_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int waited;
        rst = 1'b1; start = 1'b0; num_vec = '0; start_s = 1'b0; num_vec_s = '0;
        load_rom(8'h00);
        repeat (2) @(posedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_vec_rd", vec_rd, 0);
        rst = 1'b0;

        // zero-length run from IDLE: done right after the start edge
        run(0, 8'h00, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        // clean run: 8 + 4 + 2 cycles
        run(8, 8'h00, 0, 14, 1'b1, 1'b0, 0, 1'b0);
        // expected bits of vectors 2 and 5 flipped
        run(8, 8'b0010_0100, 2, 14, 1'b1, 1'b1, 2, 1'b0);
        // same with a start pulse (and a changed num_vec) mid-run
        run(8, 8'b0010_0100, 2, 14, 1'b1, 1'b1, 2, 1'b1);

        // reset while vector 3 is applied
        load_rom(8'b0010_0100);
        @(posedge clk); #1; num_vec = 11'd8; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #1; rst = 1'b1; #1;
        check("mid_rst_vec_rd", vec_rd, 0);
        check("mid_rst_vec_addr", vec_addr, 0);
        check("mid_rst_dut_in", dut_in, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err_count", err_count, 0);
        check("mid_rst_err_sat", err_sat, 0);
`ifdef TVEC_SEQ_FIRST_ERR_EN
        check("mid_rst_first_err_vld", first_err_vld, 0);
`endif
        @(posedge clk); #1; rst = 1'b0;

        // clean run after reset
        run(8, 8'h00, 0, 14, 1'b1, 1'b0, 0, 1'b0);

        // saturation: 6 mismatches into a 2-bit counter
        load_rom(8'hFF);
        @(posedge clk); #1; num_vec_s = 11'd6; start_s = 1'b1;
        @(posedge clk); #1; start_s = 1'b0;
        waited = 0;
        while (!done_s && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!done_s) check("sat_done_timeout", 0, 1);
        check("sat_err_count", err_count_s, 3);
        check("sat_err_sat", err_sat_s, 1);

        check("sb_leftover", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
